note_tone_generator: RTL and testbench

Produces the audible square wave for the note selected on SW[3:1] (Do, Re, Mi, Fa, So, La, Si, Do2), gated by SW[0]. It sits directly upstream of the oscilloscope note-name display. Its registered `active_note` output is the code the display decodes, so the text shown always matches the pitch being played. Switch inputs are synchronized and debounced. Pitch changes and stops take effect only on half-period boundaries, so the output never produces a runt pulse.

---
 rtl/note_tone_generator.sv | 144 ++++++++++++++
 tb/tb_note_tone_generator.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/note_tone_generator.sv
// note_tone_generator
//   Square-wave note player for the switch-selected note (Do..Do2). The
//   switches are synchronized and debounced. Pitch changes and stops are
//   applied only on half-period boundaries, so no runt pulse is produced.
//   active_note is registered so the downstream note-name display always
//   shows the pitch that is actually sounding.
//
// Ports
//   CLOCK_50     in   system clock, rising edge
//   reset        in   asynchronous, active-high reset
//   SW[9:0]      in   SW[0] play enable, SW[3:1] note select, SW[9:4] unused
//   tone_out     out  square wave to the audio path
//   active_note  out  note currently sounding (feeds the display)
//   playing      out  high while in PLAY or STOPPING
//   cycle_strobe out  one-cycle pulse in the cycle after tone_out rises
module note_tone_generator #(
  parameter int CLK_FREQ_HZ     = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int CNT_W           = 16
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [9:0] SW,
  output logic       tone_out,
  output logic [2:0] active_note,
  output logic       playing,
  output logic       cycle_strobe
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PLAY, STOPPING} state_t;

  logic [3:0]       sync1, sync2, cand, accepted;
  logic [DB_W-1:0]  db_cnt;
  logic             acc_en;
  logic [2:0]       acc_note, pending_note;
  logic [CNT_W-1:0] cnt, half;
  logic             boundary, tone_d;
  state_t           state;

  logic unused_sw;
  assign unused_sw = ^SW[9:4];

  // Two-flop synchronizer followed by a stability-counting debouncer.
  // The counter saturates once the candidate is accepted.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sync1    <= '0;
      sync2    <= '0;
      cand     <= '0;
      db_cnt   <= '0;
      accepted <= '0;
    end else begin
      sync1 <= SW[3:0];
      sync2 <= sync1;
      if (sync2 != cand) begin
        cand   <= sync2;
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        accepted <= cand;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  assign acc_en   = accepted[0];
  assign acc_note = accepted[3:1];

  // Half-period in clock cycles, always looked up from the sounding note.
  always_comb begin
    half = '0;
    case (active_note)
      3'd0: half = CNT_W'(CLK_FREQ_HZ / (2 * 523));
      3'd1: half = CNT_W'(CLK_FREQ_HZ / (2 * 587));
      3'd2: half = CNT_W'(CLK_FREQ_HZ / (2 * 659));
      3'd3: half = CNT_W'(CLK_FREQ_HZ / (2 * 698));
      3'd4: half = CNT_W'(CLK_FREQ_HZ / (2 * 783));
      3'd5: half = CNT_W'(CLK_FREQ_HZ / (2 * 880));
      3'd6: half = CNT_W'(CLK_FREQ_HZ / (2 * 987));
      3'd7: half = CNT_W'(CLK_FREQ_HZ / (2 * 1046));
      default: half = '0;
    endcase
  end

  assign boundary = (cnt == half - CNT_W'(1));

  // PLAY and STOPPING share the counting path. A low enable always wins:
  // at a boundary it ends the tone, otherwise it parks in STOPPING while the
  // current half completes. Note changes are latched only from PLAY.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      tone_out     <= 1'b0;
      tone_d       <= 1'b0;
      active_note  <= '0;
      pending_note <= '0;
      playing      <= 1'b0;
      cycle_strobe <= 1'b0;
    end else begin
      pending_note <= acc_note;
      tone_d       <= tone_out;
      cycle_strobe <= tone_out & ~tone_d;
      case (state)
        IDLE: begin
          tone_out <= 1'b0;
          cnt      <= '0;
          if (acc_en) begin
            active_note <= pending_note;
            tone_out    <= 1'b1;
            state       <= PLAY;
            playing     <= 1'b1;
          end
        end
        default: begin
          if (!acc_en) begin
            if (boundary) begin
              tone_out <= 1'b0;
              cnt      <= '0;
              state    <= IDLE;
              playing  <= 1'b0;
            end else begin
              cnt   <= cnt + CNT_W'(1);
              state <= STOPPING;
            end
          end else begin
            state <= PLAY;
            if (boundary) begin
              tone_out <= ~tone_out;
              cnt      <= '0;
              if (state == PLAY) active_note <= pending_note;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_note_tone_generator.sv
// Bench for note_tone_generator: a reduced clock frequency keeps periods
// short; a behavioural model is compared against the outputs every cycle,
// while table-driven and hand-written sequences measure phase lengths.
module tb_note_tone_generator;
  localparam int CLK_HZ = 100_000;
  localparam int DB     = 4;
  localparam int CW     = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] sw  = '0;
  logic       tone_out, playing, cycle_strobe;
  logic [2:0] active_note;

  int checks = 0, failures = 0, printed = 0;

  note_tone_generator #(.CLK_FREQ_HZ(CLK_HZ), .DEBOUNCE_CYCLES(DB), .CNT_W(CW)) dut (
    .CLOCK_50(clk), .reset(rst), .SW(sw), .tone_out(tone_out),
    .active_note(active_note), .playing(playing), .cycle_strobe(cycle_strobe));

  always #5 clk = ~clk;

  function automatic int freq_of(input int n);
    case (n)
      0: return 523;  1: return 587;  2: return 659;  3: return 698;
      4: return 783;  5: return 880;  6: return 987;  default: return 1046;
    endcase
  endfunction

  function automatic int half_of(input logic [2:0] n);
    return CLK_HZ / (2 * freq_of(int'(n)));
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Switches are seen two cycles late; a value is accepted once it has been
  // seen unchanged on DB+1 consecutive edges. The tone is a run of halves,
  // each lasting half_of(note) cycles, tracked with a remaining-cycle count.
  logic [3:0] m_s1, m_s2, m_runval, m_acc, s2o, acco;
  logic [2:0] m_pend, m_note, pendo;
  logic       m_tone, m_tone_d, m_strobe, toneo, toned, en, last;
  int         m_run, m_mode, m_left;  // mode: 0 silent, 1 playing, 2 stopping

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_runval = '0; m_acc = '0; m_run = 1;
      m_pend = '0; m_note = '0; m_mode = 0; m_left = 0;
      m_tone = 1'b0; m_tone_d = 1'b0; m_strobe = 1'b0;
    end else begin
      s2o = m_s2; acco = m_acc; pendo = m_pend;
      toneo = m_tone; toned = m_tone_d; en = acco[0];
      m_s2 = m_s1;
      m_s1 = sw[3:0];
      if (s2o == m_runval) m_run++;
      else begin m_runval = s2o; m_run = 1; end
      if (m_run > DB + 1) m_run = DB + 1;
      if (m_run == DB + 1) m_acc = m_runval;
      m_pend   = acco[3:1];
      m_tone_d = toneo;
      m_strobe = toneo & ~toned;
      if (m_mode == 0) begin
        if (en) begin
          m_mode = 1; m_tone = 1'b1; m_note = pendo; m_left = half_of(pendo);
        end
      end else begin
        last = (m_left == 1);
        if (!en) begin
          if (last) begin m_tone = 1'b0; m_mode = 0; end
          else begin m_left--; m_mode = 2; end
        end else begin
          if (last) begin
            m_tone = ~m_tone;
            if (m_mode == 1) m_note = pendo;
            m_left = half_of(m_note);
          end else m_left--;
          m_mode = 1;
        end
      end
    end
  end

  task automatic mcmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      if (printed < 20) begin
        printed++;
        $display("FAIL model_%s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mcmp("tone_out", int'(tone_out), int'(m_tone));
      mcmp("active_note", int'(active_note), int'(m_note));
      mcmp("playing", int'(playing), (m_mode != 0) ? 1 : 0);
      mcmp("cycle_strobe", int'(cycle_strobe), int'(m_strobe));
    end
  end

  // ---------------- helpers ----------------
  task automatic do_reset(input logic [9:0] sw_val);
    rst = 1'b1;
    sw  = sw_val;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_playing(input int limit, output int n);
    n = 0;
    while (!playing && n < limit) begin @(negedge clk); n++; end
    if (!playing) begin
      checks++; failures++;
      $display("FAIL playing_wait: playing still 0 after %0d cycles", n);
    end
  endtask

  task automatic run_until(input logic v, input int limit, output int n, output int strb);
    n = 0; strb = 0;
    do begin
      @(negedge clk); n++;
      if (cycle_strobe) strb++;
    end while (tone_out !== v && n < limit);
    if (tone_out !== v) begin
      checks++; failures++;
      $display("FAIL tone_wait: tone_out %b after %0d cycles, wanted %b", tone_out, n, v);
    end
  endtask

  typedef struct {
    logic [2:0] note;
    int         exp_half;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int n, s, s2, lat, act;
    vecs[0] = '{3'd0, 95}; vecs[1] = '{3'd1, 85}; vecs[2] = '{3'd2, 75}; vecs[3] = '{3'd3, 71};
    vecs[4] = '{3'd4, 63}; vecs[5] = '{3'd5, 56}; vecs[6] = '{3'd6, 50}; vecs[7] = '{3'd7, 47};

    // Reset values and idle hold
    do_reset(10'b0);
    chk("rst_tone", int'(tone_out), 0);
    chk("rst_note", int'(active_note), 0);
    chk("rst_playing", int'(playing), 0);
    chk("rst_strobe", int'(cycle_strobe), 0);
    act = 0;
    repeat (50) begin
      @(negedge clk);
      if (tone_out || playing || cycle_strobe || active_note != 0) act++;
    end
    chk("idle_activity", act, 0);

    // Every note: latency, sounding note, both phase lengths, one strobe
    foreach (vecs[i]) begin
      do_reset({6'b0, vecs[i].note, 1'b0});
      repeat (15) @(negedge clk);
      sw = {6'b0, vecs[i].note, 1'b1};
      wait_playing(40, lat);
      chk_rng($sformatf("latency_%0d", i), lat, DB + 3, DB + 4);
      chk($sformatf("note_%0d", i), int'(active_note), int'(vecs[i].note));
      run_until(1'b0, 200, n, s);
      chk($sformatf("high_%0d", i), n, vecs[i].exp_half);
      run_until(1'b1, 200, n, s2);
      chk($sformatf("low_%0d", i), n, vecs[i].exp_half);
      chk($sformatf("strobes_%0d", i), s + s2, 1);
    end

    // Do -> Do2 mid high phase: the high phase completes at full length
    do_reset(10'b0);
    repeat (15) @(negedge clk);
    sw = 10'b0000000001;
    wait_playing(40, lat);
    repeat (10) @(negedge clk);
    sw = 10'b0000001111;
    run_until(1'b0, 200, n, s);
    chk("do_high_full", 10 + n, 95);
    chk("do2_latched", int'(active_note), 7);
    run_until(1'b1, 200, n, s);
    chk("do2_low", n, 47);
    run_until(1'b0, 200, n, s);
    chk("do2_high", n, 47);

    // La with a 3-cycle bounce on the enable: tone undisturbed
    do_reset(10'b0000001010);
    repeat (15) @(negedge clk);
    sw = 10'b0000001011;
    wait_playing(40, lat);
    repeat (20) @(negedge clk);
    sw = 10'b0000001010;
    repeat (3) @(negedge clk);
    sw = 10'b0000001011;
    run_until(1'b0, 200, n, s);
    chk("la_high", 23 + n, 56);
    chk("la_playing", int'(playing), 1);
    run_until(1'b1, 200, n, s);
    chk("la_low", n, 56);

    // Re stop during high phase
    do_reset(10'b0000000010);
    repeat (15) @(negedge clk);
    sw = 10'b0000000011;
    wait_playing(40, lat);
    repeat (5) @(negedge clk);
    sw = 10'b0000000010;
    run_until(1'b0, 200, n, s);
    chk("re_stop_high", 5 + n, 85);
    chk("re_stop_playing", int'(playing), 0);
    chk("re_stop_note", int'(active_note), 1);
    act = 0;
    repeat (200) begin @(negedge clk); if (tone_out || playing) act++; end
    chk("re_stays_idle", act, 0);

    // Re stop then re-enable before the boundary: phase unchanged
    do_reset(10'b0000000010);
    repeat (15) @(negedge clk);
    sw = 10'b0000000011;
    wait_playing(40, lat);
    repeat (5) @(negedge clk);
    sw = 10'b0000000010;
    repeat (20) @(negedge clk);
    sw = 10'b0000000011;
    run_until(1'b0, 200, n, s);
    chk("re_resume_high", 25 + n, 85);
    chk("re_resume_playing", int'(playing), 1);
    run_until(1'b1, 200, n, s);
    chk("re_resume_low", n, 85);

    // Si: asynchronous reset mid high phase
    do_reset(10'b0000001100);
    repeat (15) @(negedge clk);
    sw = 10'b0000001101;
    wait_playing(40, lat);
    repeat (10) @(negedge clk);
    chk("si_pre_tone", int'(tone_out), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_tone", int'(tone_out), 0);
    chk("async_note", int'(active_note), 0);
    chk("async_playing", int'(playing), 0);
    chk("async_strobe", int'(cycle_strobe), 0);
    @(negedge clk);
    rst = 1'b0;

    // Randomized switch activity, including bounces shorter than DB
    do_reset(10'b0);
    for (int k = 0; k < 250; k++) begin
      sw    = 10'($urandom);
      sw[0] = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) repeat ($urandom_range(60, 150)) @(negedge clk);
      else repeat ($urandom_range(1, 10)) @(negedge clk);
    end
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
